// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: WIDTH-cycle latency (WIDTH+1 with MUL_SIGNED_EN), one operation
// in flight, start ignored while busy; define MUL_SIGNED_EN for two's-complement operands.
module mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
`ifdef MUL_SIGNED_EN
    FIX,
`endif
    DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     a_op;
  logic [WIDTH-1:0]     b_op;
  logic                 last;

`ifdef MUL_SIGNED_EN
  logic                 neg;
  logic [2*WIDTH-1:0]   acc_fix;

  // Magnitudes of the most negative value wrap back to itself, which is the correct unsigned magnitude.
  assign a_op    = a[WIDTH-1] ? -a : a;
  assign b_op    = b[WIDTH-1] ? -b : b;
  assign acc_fix = neg ? -acc : acc;
`else
  assign a_op = a;
  assign b_op = b;
`endif

  // Upper half accumulates the partial product; lower half holds the remaining multiplier bits.
  assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
  assign acc_step = {sum, acc[WIDTH-1:1]};
  assign last     = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      lo    <= '0;
      hi    <= '0;
      acc   <= '0;
      cnt   <= '0;
      mcand <= '0;
`ifdef MUL_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a_op;
            acc   <= {{WIDTH{1'b0}}, b_op};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef MUL_SIGNED_EN
            neg   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (last) begin
`ifdef MUL_SIGNED_EN
            state <= FIX;
`else
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            {hi, lo}   <= acc_step;
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        FIX: begin
          acc      <= acc_fix;
          {hi, lo} <= acc_fix;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
`endif
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: expected products are queued at start and checked on each done pulse.
module tb_mul_seq;
  localparam int W = 16;
`ifdef MUL_SIGNED_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] lo;
  logic [W-1:0] hi;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_exp;

  mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .lo(lo), .hi(hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      check("busy_with_done", {63'd0, busy}, 64'd0);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h, expected no done pulse", hi, lo);
      end else begin
        mon_exp = exp_q.pop_front();
        check("product", {32'd0, hi, lo}, {32'd0, mon_exp});
      end
    end
  end

  // Caller is at a negedge; returns at a negedge one cycle after done.
  task automatic run_mul(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2*W-1:0] expv);
    logic [2*W-1:0] held;
    int n;
    bit changed;
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(expv);
    held = {hi, lo};
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n = 0;
    changed = 1'b0;
    while (busy && n < 200) begin
      if ({hi, lo} !== held) changed = 1'b1;
      n++;
      @(negedge clk);
    end
    check("latency", 64'(n), 64'(LAT));
    check("hold_while_busy", {63'd0, changed}, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int d0;
    int n;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_lohi", {32'd0, hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_mul(16'h0003, 16'h0005, 32'h0000_000F);
`ifdef MUL_SIGNED_EN
    run_mul(16'hFFFF, 16'hFFFF, 32'h0000_0001);
    run_mul(16'hFFFF, 16'h0002, 32'hFFFF_FFFE);
    run_mul(16'h8000, 16'h8000, 32'h4000_0000);
    run_mul(16'h8000, 16'h0001, 32'hFFFF_8000);
`else
    run_mul(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
`endif
    run_mul(16'h0000, 16'h1234, 32'h0000_0000);
    run_mul(16'h1234, 16'h5678, 32'h0626_0060);

    // A second start mid-run must be ignored.
    d0 = done_cnt;
    a = 16'h0010;
    b = 16'h0010;
    start = 1'b1;
    exp_q.push_back(32'h0000_0100);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 16'h0001;
    b = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'hA5A5;
    b = 16'h5A5A;
    n = 0;
    while (done_cnt == d0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    repeat (30) @(negedge clk);
    check("single_done", 64'(done_cnt - d0), 64'd1);
    check("idle_after_ignored_start", {63'd0, busy}, 64'd0);

    // Reset in the middle of a run aborts it without a done pulse.
    a = 16'h00FF;
    b = 16'h00FF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_lohi", {32'd0, hi, lo}, 64'd0);
    d0 = done_cnt;
    repeat (30) @(negedge clk);
    check("no_done_after_abort", 64'(done_cnt), 64'(d0));

    run_mul(16'h00FF, 16'h00FF, 32'h0000_FE01);

    // Result holds while idle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_hold_lohi", {32'd0, hi, lo}, 64'h0000_FE01);
      check("idle_done_low", {63'd0, done}, 64'd0);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
